// File: rtl/mips_commit_trace.sv
// Commit trace capture: forms 24-bit records from core write strobes, queues them in a
// FIFO and serializes each record as three bytes over a valid/ready byte stream.
module mips_commit_trace #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RegWrite,
    input  logic       MemWrite,
    input  logic [5:0] PCout,
    input  logic [4:0] WriteReg,
    input  logic [7:0] WriteBack,
    input  logic [7:0] ALUResult,
    input  logic [7:0] readd2,
    input  logic       capture_en,
    input  logic       clear,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic [6:0] fifo_level,
    output logic       overflow,
    output logic [7:0] drop_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [6:0] DEPTH_L = 7'(DEPTH);

    typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;

    state_t        state;
    state_t        state_next;
    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [6:0]    level;
    logic [23:0]   cur;
    logic [23:0]   rec;
    logic          rec_valid;
    logic          pop;
    logic          push;
    logic          drop;

    always_comb begin
        rec       = '0;
        rec_valid = 1'b0;
        if (capture_en && RegWrite) begin
            rec       = {(MemWrite ? 2'b11 : 2'b01), PCout, 3'b000, WriteReg, WriteBack};
            rec_valid = 1'b1;
        end else if (capture_en && MemWrite) begin
            rec       = {2'b10, PCout, ALUResult, readd2};
            rec_valid = 1'b1;
        end
    end

    // A pop happens on leaving IDLE or on final-byte acceptance, so a full FIFO can
    // still take a record on the edge that frees a slot.
    assign pop  = (level != '0) && ((state == IDLE) || ((state == B2) && out_ready));
    assign push = rec_valid && ((level < DEPTH_L) || pop);
    assign drop = rec_valid && !push;

    always_comb begin
        state_next = state;
        out_valid  = 1'b1;
        out_byte   = '0;
        case (state)
            IDLE: begin
                out_valid = 1'b0;
                if (pop) state_next = B0;
            end
            B0: begin
                out_byte = cur[23:16];
                if (out_ready) state_next = B1;
            end
            B1: begin
                out_byte = cur[15:8];
                if (out_ready) state_next = B2;
            end
            B2: begin
                out_byte = cur[7:0];
                if (out_ready) state_next = pop ? B0 : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cur    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            state <= state_next;
            if (pop) begin
                cur    <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + 7'd1;
                2'b01:   level <= level - 7'd1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

    assign fifo_level = level;

endmodule

// File: tb/tb_mips_commit_trace.sv
// Bench for mips_commit_trace: directed scenarios and random traffic checked against a
// queue-based model of record capture, buffering and byte-wise emission.
module tb_mips_commit_trace;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst;
    logic       RegWrite;
    logic       MemWrite;
    logic [5:0] PCout;
    logic [4:0] WriteReg;
    logic [7:0] WriteBack;
    logic [7:0] ALUResult;
    logic [7:0] readd2;
    logic       capture_en;
    logic       clear;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic [6:0] fifo_level;
    logic       overflow;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;

    // Model: records waiting, record being emitted and which of its bytes is showing.
    logic [23:0] mq[$];
    bit          m_busy;
    logic [23:0] m_rec;
    int          m_idx;
    bit          m_ovf;
    int          m_drops;

    mips_commit_trace #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .PCout      (PCout),
        .WriteReg   (WriteReg),
        .WriteBack  (WriteBack),
        .ALUResult  (ALUResult),
        .readd2     (readd2),
        .capture_en (capture_en),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy  = 0;
        m_rec   = '0;
        m_idx   = 0;
        m_ovf   = 0;
        m_drops = 0;
    endtask

    function automatic logic [7:0] model_byte();
        if (!m_busy) return 8'h00;
        case (m_idx)
            0:       return m_rec[23:16];
            1:       return m_rec[15:8];
            default: return m_rec[7:0];
        endcase
    endfunction

    // Advance the model across one rising edge using the inputs present at that edge.
    task automatic model_edge();
        bit          have_rec;
        logic [23:0] r;
        bit          finishing;
        bit          take;
        have_rec  = 0;
        r         = '0;
        if (capture_en && RegWrite) begin
            have_rec = 1;
            r = {(MemWrite ? 2'b11 : 2'b01), PCout, 3'b000, WriteReg, WriteBack};
        end else if (capture_en && MemWrite) begin
            have_rec = 1;
            r = {2'b10, PCout, ALUResult, readd2};
        end
        finishing = m_busy && out_ready && (m_idx == 2);
        take      = (mq.size() > 0) && (!m_busy || finishing);
        if (m_busy && out_ready) begin
            if (m_idx == 2) m_busy = 0;
            else m_idx++;
        end
        if (take) begin
            m_rec  = mq.pop_front();
            m_busy = 1;
            m_idx  = 0;
        end
        if (have_rec) begin
            if (mq.size() < DEPTH) mq.push_back(r);
            else if (!clear) begin
                m_ovf   = 1;
                m_drops = (m_drops < 255) ? m_drops + 1 : 255;
            end
        end
        if (clear) begin
            m_ovf   = 0;
            m_drops = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".out_valid"},  32'(out_valid),  32'(m_busy));
        check({tag, ".out_byte"},   32'(out_byte),   32'(model_byte()));
        check({tag, ".fifo_level"}, 32'(fifo_level), 32'(mq.size()));
        check({tag, ".overflow"},   32'(overflow),   32'(m_ovf));
        check({tag, ".drop_count"}, 32'(drop_count), 32'(m_drops));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        RegWrite = 0; MemWrite = 0; clear = 0;
    endtask

    task automatic set_reg(input logic [5:0] pc, input logic [4:0] wr, input logic [7:0] wb);
        RegWrite = 1; MemWrite = 0; PCout = pc; WriteReg = wr; WriteBack = wb;
    endtask

    initial begin
        rst = 1; capture_en = 1; out_ready = 1;
        RegWrite = 0; MemWrite = 0; clear = 0;
        PCout = '0; WriteReg = '0; WriteBack = '0; ALUResult = '0; readd2 = '0;
        model_reset();
        #22;
        compare_all("reset");
        #1 rst = 0;

        // Single register write, expected bytes 45 03 A5 from the edge after capture.
        set_reg(6'h05, 5'd3, 8'hA5);
        step("rw_push");
        check("rw_push.level", 32'(fifo_level), 32'd1);
        idle_inputs();
        step("rw_b0");
        check("rw_b0.byte", 32'(out_byte), 32'h45);
        step("rw_b1");
        check("rw_b1.byte", 32'(out_byte), 32'h03);
        step("rw_b2");
        check("rw_b2.byte", 32'(out_byte), 32'hA5);
        step("rw_idle");
        check("rw_idle.valid", 32'(out_valid), 32'd0);

        // Store record.
        MemWrite = 1; PCout = 6'h02; ALUResult = 8'h10; readd2 = 8'h7F;
        step("st_push");
        idle_inputs();
        step("st_b0");
        check("st_b0.byte", 32'(out_byte), 32'h82);
        step("st_b1");
        check("st_b1.byte", 32'(out_byte), 32'h10);
        step("st_b2");
        check("st_b2.byte", 32'(out_byte), 32'h7F);
        step("st_idle");

        // Both strobes: kind 11 with register fields; backpressure held during byte1.
        set_reg(6'h3F, 5'd31, 8'h5A); MemWrite = 1;
        step("both_push");
        idle_inputs();
        step("both_b0");
        check("both_b0.byte", 32'(out_byte), 32'hFF);
        step("both_b1");
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            step("bp_hold");
            check("bp_hold.byte", 32'(out_byte), 32'h1F);
        end
        out_ready = 1;
        step("bp_b2");
        check("bp_b2.byte", 32'(out_byte), 32'h5A);
        step("bp_idle");

        // Overflow: DEPTH+3 commits with the sink stalled.
        out_ready = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            set_reg(6'(i), 5'(i), 8'(8'h30 + i));
            step("ovf_fill");
        end
        idle_inputs();
        check("ovf.level", 32'(fifo_level), 32'(DEPTH));
        check("ovf.drops", 32'(drop_count), 32'd2);
        check("ovf.flag",  32'(overflow), 32'd1);
        check("ovf.valid", 32'(out_valid), 32'd1);
        clear = 1;
        step("ovf_clear");
        clear = 0;
        check("clr.drops", 32'(drop_count), 32'd0);
        check("clr.flag",  32'(overflow), 32'd0);
        check("clr.level", 32'(fifo_level), 32'(DEPTH));

        // Full FIFO plus pop on the same edge as a new commit.
        out_ready = 1;
        step("fp_b1");
        step("fp_b2");
        set_reg(6'h11, 5'd7, 8'hC3);
        step("fp_pop_push");
        idle_inputs();
        check("fp.level", 32'(fifo_level), 32'(DEPTH));
        check("fp.drops", 32'(drop_count), 32'd0);
        // Draining continues with capture disabled.
        capture_en = 0;
        RegWrite = 1;
        for (int i = 0; i < 3 * DEPTH + 4; i++) step("drain");
        RegWrite = 0;
        capture_en = 1;
        check("drain.level", 32'(fifo_level), 32'd0);
        check("drain.valid", 32'(out_valid), 32'd0);

        // Asynchronous reset while showing byte2.
        set_reg(6'h0A, 5'd1, 8'h99);
        step("ar_push0");
        step("ar_push1");
        idle_inputs();
        step("ar_b1");
        step("ar_b2");
        check("ar_b2.byte", 32'(out_byte), 32'h99);
        #2 rst = 1;
        model_reset();
        #1;
        compare_all("ar_mid");
        check("ar_mid.valid", 32'(out_valid), 32'd0);
        check("ar_mid.level", 32'(fifo_level), 32'd0);
        #1 rst = 0;
        for (int i = 0; i < 3; i++) step("ar_quiet");

        // Drop counter saturation.
        out_ready = 0;
        for (int i = 0; i < DEPTH + 262; i++) begin
            set_reg(6'($urandom), 5'($urandom), 8'($urandom));
            step("sat");
        end
        idle_inputs();
        check("sat.drops", 32'(drop_count), 32'd255);
        clear = 1; RegWrite = 1;
        step("clr_drop");
        idle_inputs();
        check("clr_drop.drops", 32'(drop_count), 32'd0);
        out_ready = 1;

        // Random traffic with bursty backpressure and occasional clear.
        for (int i = 0; i < 3000; i++) begin
            capture_en = ($urandom_range(0, 7) != 0);
            RegWrite   = $urandom_range(0, 2) == 0;
            MemWrite   = $urandom_range(0, 2) == 0;
            PCout      = 6'($urandom);
            WriteReg   = 5'($urandom);
            WriteBack  = 8'($urandom);
            ALUResult  = 8'($urandom);
            readd2     = 8'($urandom);
            clear      = ($urandom_range(0, 60) == 0);
            if ((i / 200) % 2 == 0) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_commit_trace.md
MIPS_COMMIT_TRACE -- requirements
Module: mips_commit_trace

Interface
REQ-001 Parameter DEPTH, default 8, FIFO record capacity; SHALL be a power of two, 2..64.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 RegWrite  input  1  register-file write strobe from the core for the current instruction.
REQ-005 MemWrite  input  1  data-memory write strobe from the core for the current instruction.
REQ-006 PCout  input  6  PC of the committing instruction.
REQ-007 WriteReg  input  5  destination register of the committing instruction.
REQ-008 WriteBack  input  8  value written to the register file.
REQ-009 ALUResult  input  8  data-memory address for stores.
REQ-010 readd2  input  8  store data.
REQ-011 capture_en  input  1  capture enable; 0 SHALL ignore all strobes.
REQ-012 clear  input  1  synchronous clear of overflow and drop_count.
REQ-013 out_valid  output  1  out_byte holds a valid trace byte.
REQ-014 out_ready  input  1  sink accepts out_byte when out_valid=1.
REQ-015 out_byte  output  8  serialized trace byte.
REQ-016 fifo_level  output  7  number of records held in the FIFO, excluding the record being serialized.
REQ-017 overflow  output  1  sticky flag: at least one record has been dropped.
REQ-018 drop_count  output  8  saturating count of dropped records.

Function
REQ-019 Each rising edge with capture_en=1 and RegWrite=1 SHALL form record {kind=2'b01, PCout, 3'b000+WriteReg, WriteBack}.
REQ-020 With capture_en=1 and MemWrite=1 and RegWrite=0, the block SHALL form record {kind=2'b10, PCout, ALUResult, readd2}.
REQ-021 If RegWrite and MemWrite are both 1 on the same edge, the block SHALL form the kind 2'b11 record with the RegWrite fields; only one record is formed.
REQ-022 Record width SHALL be 24 bits: byte0={kind,PC}, byte1=tag, byte2=value.
REQ-023 A formed record SHALL be pushed into the FIFO on the same edge when fifo_level<DEPTH, or when fifo_level=DEPTH and a pop occurs on that edge.
REQ-024 Otherwise the record SHALL be dropped: overflow is set to 1 and drop_count increments, saturating at 255.
REQ-025 Serializer states: IDLE, B0, B1, B2.
REQ-026 IDLE -> B0 when the FIFO is non-empty; this transition pops one record.
REQ-027 In states B0, B1 and B2, out_valid=1 and out_byte carries byte0, byte1 and byte2 respectively.
REQ-028 A byte SHALL advance only on an edge with out_valid=1 and out_ready=1.
REQ-029 While out_ready=0, out_byte SHALL hold stable.
REQ-030 On acceptance in B2, the serializer SHALL go to B0 with a new pop if the FIFO is non-empty, otherwise to IDLE, so back-to-back records have no bubble.
REQ-031 Latency, empty FIFO with IDLE serializer: record pushed at edge N; popped at edge N+1; out_valid=1 after edge N+1.
REQ-032 Throughput SHALL be one byte per clock while out_ready=1.
REQ-033 out_valid SHALL be 0 in IDLE.
REQ-034 fifo_level SHALL wrap-free track pushes minus pops; read and write pointers SHALL wrap modulo DEPTH.
REQ-035 Push and pop on the same edge SHALL leave fifo_level unchanged.
REQ-036 clear=1 SHALL zero overflow and drop_count at the next edge; clear SHALL NOT affect the FIFO or the serializer.
REQ-037 If a drop and clear coincide, the drop is cleared and the result is overflow=0, drop_count=0.
REQ-038 capture_en=0 SHALL NOT stall draining of records already queued.

Reset
REQ-039 rst=1 SHALL immediately force: serializer=IDLE, out_valid=0, out_byte=0, FIFO pointers=0, fifo_level=0, overflow=0, drop_count=0.
REQ-040 Reset mid-record SHALL discard the partial record and all queued records without emitting further bytes.
REQ-041 After rst deasserts, the first capture SHALL occur on the next rising edge.

Verification
REQ-042 Single regwrite: RegWrite=1, PCout=6'h05, WriteReg=3, WriteBack=8'hA5, out_ready=1 -> bytes 8'h45, 8'h03, 8'hA5 on three consecutive cycles starting edge N+1.
REQ-043 Store: MemWrite=1, PCout=6'h02, ALUResult=8'h10, readd2=8'h7F -> bytes 8'h82, 8'h10, 8'h7F.
REQ-044 Backpressure: out_ready=0 for 5 cycles during B1 -> out_byte holds byte1 throughout; full record emitted with no duplicated or lost byte.
REQ-045 Overflow: out_ready=0, DEPTH+3 consecutive RegWrite commits -> one record in serializer, fifo_level=DEPTH, drop_count=2, overflow=1; clear -> both 0 next edge.
REQ-046 Full plus pop: FIFO full, out_ready=1 with a pop on the same edge as a new RegWrite -> record accepted, drop_count unchanged.
REQ-047 Async reset in B2: rst pulse between clock edges -> out_valid=0 and fifo_level=0 before the next edge; no further bytes until a new capture.
